// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK bit-cells with clear/preset, per-bit JK mode and a binary counter mode.
// Optional macro JK_CNT_DOWN_EN adds input dn for down-counting in counter mode.
module jk_reg_bank #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             preset,
  input  logic             en,
  input  logic             mode,
`ifdef JK_CNT_DOWN_EN
  input  logic             dn,
`endif
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             chg
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qbar_q;
  logic             chg_q;
  logic [WIDTH-1:0] tgl;
  logic             cnt_dn;

`ifdef JK_CNT_DOWN_EN
  assign cnt_dn = dn;
`else
  assign cnt_dn = 1'b0;
`endif

  // Ripple toggle condition: bit i flips when all lower bits are ones (up) or zeros (down).
  always_comb begin
    logic run;
    run = 1'b1;
    tgl = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tgl[i] = run;
      run    = run & (cnt_dn ? ~q_q[i] : q_q[i]);
    end
  end

  always_comb begin
    q_d = q_q;
    if (clr)         q_d = '0;
    else if (preset) q_d = '1;
    else if (!en)    q_d = q_q;
    else if (mode)   q_d = q_q ^ tgl;
    else             q_d = (j & ~q_q) | (~k & q_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q    <= RST_VAL;
      qbar_q <= ~RST_VAL;
      chg_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      qbar_q <= ~q_d;
      chg_q  <= (q_d != q_q);
    end
  end

  assign q    = q_q;
  assign qbar = qbar_q;
  assign chg  = chg_q;
  assign tc   = mode & en & (cnt_dn ? (q_q == '0) : (q_q == '1));

endmodule

// File: tb/tb_jk_reg_bank.sv
// Randomized self-checking bench for jk_reg_bank against a behavioural model.
module tb_jk_reg_bank;

  localparam int         W   = 8;
  localparam logic [7:0] RST = 8'h5A;

  logic         clk = 1'b0;
  logic         rst_n, clr, preset, en, mode, dn;
  logic [W-1:0] j, k, q, qbar;
  logic         tc, chg;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q;
  logic         exp_chg;

  jk_reg_bank #(.WIDTH(W), .RST_VAL(RST)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .preset(preset), .en(en), .mode(mode),
`ifdef JK_CNT_DOWN_EN
    .dn(dn),
`endif
    .j(j), .k(k), .q(q), .qbar(qbar), .tc(tc), .chg(chg)
  );

  always #5 clk = ~clk;

  function automatic logic down_active();
`ifdef JK_CNT_DOWN_EN
    return dn;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_tc();
    if (!(mode && en)) return 1'b0;
    if (down_active()) return exp_q == 8'h00;
    return exp_q == 8'hFF;
  endfunction

  // Drive one set of inputs, let one rising edge pass, advance the model, settle at negedge.
  task automatic tick(input logic r, input logic c, input logic p, input logic e,
                      input logic m, input logic [W-1:0] jj, input logic [W-1:0] kk);
    logic [W-1:0] old_q, new_q;
    rst_n = r; clr = c; preset = p; en = e; mode = m; j = jj; k = kk;
    @(posedge clk);
    old_q = exp_q;
    if (!r)       new_q = RST;
    else if (c)   new_q = 8'h00;
    else if (p)   new_q = 8'hFF;
    else if (!e)  new_q = old_q;
    else if (m)   new_q = down_active() ? old_q - 8'd1 : old_q + 8'd1;
    else begin
      for (int b = 0; b < W; b++) begin
        case ({jj[b], kk[b]})
          2'b00:   new_q[b] = old_q[b];
          2'b01:   new_q[b] = 1'b0;
          2'b10:   new_q[b] = 1'b1;
          default: new_q[b] = ~old_q[b];
        endcase
      end
    end
    exp_chg = r && (new_q != old_q);
    exp_q   = new_q;
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
    checks++; if (q !== 8'h5A)  begin errors++; $display("FAIL reset_q got %h want 5a", q); end
    checks++; if (qbar !== 8'hA5) begin errors++; $display("FAIL reset_qbar got %h want a5", qbar); end
    checks++; if (chg !== 1'b0) begin errors++; $display("FAIL reset_chg got %b want 0", chg); end
    checks++; if (tc !== 1'b0)  begin errors++; $display("FAIL reset_tc got %b want 0", tc); end
  endtask

  task automatic test_jk();
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0F, 8'hF0);
    checks++; if (q !== 8'h0F) begin errors++; $display("FAIL jk_load got %h want 0f", q); end
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 8'h3C);
    checks++; if (q !== 8'hF3) begin errors++; $display("FAIL jk_mix got %h want f3", q); end
    checks++; if (chg !== 1'b1) begin errors++; $display("FAIL jk_chg got %b want 1", chg); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL jk_tc got %b want 0", tc); end
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 8'h00);
    checks++; if (chg !== 1'b0) begin errors++; $display("FAIL jk_noop_chg got %b want 0", chg); end
  endtask

  task automatic test_counter_wrap();
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFE, 8'h01);
    mode = 1'b1; #1;
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL wrap_tc_fe got %b want 0", tc); end
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL wrap_ff got %h want ff", q); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL wrap_tc_ff got %b want 1", tc); end
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5C, 8'hA3);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL wrap_00 got %h want 00", q); end
    checks++; if (tc !== 1'b0 || chg !== 1'b1) begin errors++; $display("FAIL wrap_flags got tc=%b chg=%b want tc=0 chg=1", tc, chg); end
  endtask

  task automatic test_clr_preset();
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h00);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL clr_wins got %h want 00", q); end
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF);
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL preset got %h want ff", q); end
    checks++; if (qbar !== 8'h00) begin errors++; $display("FAIL preset_qbar got %h want 00", qbar); end
  endtask

  task automatic test_hold_then_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'hEF);
    for (int n = 0; n < 3; n++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, $urandom, $urandom);
      checks++; if (q !== 8'h10 || chg !== 1'b0) begin errors++; $display("FAIL hold_%0d got q=%h chg=%b want q=10 chg=0", n, q, chg); end
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    checks++; if (q !== 8'h5A || chg !== 1'b0) begin errors++; $display("FAIL hold_reset got q=%h chg=%b want q=5a chg=0", q, chg); end
  endtask

  task automatic test_mode_switch();
    for (int n = 0; n < 3; n++) tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    checks++; if (q !== 8'h5D) begin errors++; $display("FAIL switch_count got %h want 5d", q); end
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    checks++; if (q !== 8'h5D || chg !== 1'b0) begin errors++; $display("FAIL switch_keep got q=%h chg=%b want q=5d chg=0", q, chg); end
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);
    checks++; if (q !== 8'h5E) begin errors++; $display("FAIL switch_back got %h want 5e", q); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      tick(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom, $urandom);
      checks++;
      if (q !== exp_q || qbar !== ~exp_q || chg !== exp_chg || tc !== exp_tc()) begin
        errors++;
        $display("FAIL random_%0d got q=%h qbar=%h chg=%b tc=%b want q=%h qbar=%h chg=%b tc=%b",
                 n, q, qbar, chg, tc, exp_q, ~exp_q, exp_chg, exp_tc());
      end
    end
  endtask

`ifdef JK_CNT_DOWN_EN
  task automatic test_down();
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 8'hFE);
    dn = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    checks++; if (q !== 8'h00 || tc !== 1'b1) begin errors++; $display("FAIL down_00 got q=%h tc=%b want q=00 tc=1", q, tc); end
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    checks++; if (q !== 8'hFF || tc !== 1'b0) begin errors++; $display("FAIL down_ff got q=%h tc=%b want q=ff tc=0", q, tc); end
    for (int n = 0; n < 100; n++) begin
      dn = $urandom_range(0, 1);
      tick(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom, $urandom);
      checks++;
      if (q !== exp_q || chg !== exp_chg || tc !== exp_tc()) begin
        errors++;
        $display("FAIL down_rand_%0d got q=%h chg=%b tc=%b want q=%h chg=%b tc=%b", n, q, chg, tc, exp_q, exp_chg, exp_tc());
      end
    end
    dn = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0; clr = 1'b0; preset = 1'b0; en = 1'b0; mode = 1'b0; dn = 1'b0;
    j = '0; k = '0; exp_q = 'x; exp_chg = 1'b0;
    @(negedge clk);
    test_reset();
    test_jk();
    test_counter_wrap();
    test_clr_preset();
    test_hold_then_reset();
    test_mode_switch();
    test_random();
`ifdef JK_CNT_DOWN_EN
    test_down();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_reg_bank.md
JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
REQ-001 Parameter WIDTH, default 8: number of JK bit-cells in the bank, legal range 2..32.
REQ-002 Parameter RST_VAL, default 0: WIDTH-bit value loaded into q on reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 clr  input  1  synchronous functional clear, active-high.
REQ-006 preset  input  1  synchronous functional preset, active-high.
REQ-007 en  input  1  cell/count enable; when low, q holds.
REQ-008 mode  input  1  0 = per-bit JK mode, 1 = counter mode.
REQ-009 j  input  WIDTH  per-bit J inputs, used in JK mode only.
REQ-010 k  input  WIDTH  per-bit K inputs, used in JK mode only.
REQ-011 q  output  WIDTH  registered bank state.
REQ-012 qbar  output  WIDTH  registered complement of q.
REQ-013 tc  output  1  terminal-count flag, combinational from q, mode and en.
REQ-014 chg  output  1  registered pulse: q changed on the previous rising edge.

Function
REQ-015 Update priority at each rising edge: rst_n low > clr > preset > en low (hold) > mode action.
REQ-016 clr high: q <= all zeros; preset high: q <= all ones; clr wins when both are high.
REQ-017 JK mode, per bit i: {j,k}=00 hold, 01 q[i]<=0, 10 q[i]<=1, 11 q[i]<=~q[i]; all bits are independent and update in the same cycle.
REQ-018 Counter mode: bit i toggles when en=1 and q[i-1:0] are all ones (bit 0 always toggles), giving q <= q+1 mod 2^WIDTH; j and k are ignored.
REQ-019 Counter wrap: all-ones -> all-zeros in one clock with no stall.
REQ-020 tc = mode & en & (q == all ones) in up-count; tc = 0 in JK mode.
REQ-021 qbar equals ~q in every cycle, including the reset cycle; no cycle exposes q and qbar equal.
REQ-022 chg is 1 in the cycle after any edge where q took a new value, otherwise 0; holds and no-op JK writes give chg = 0.
REQ-023 Changing mode takes effect on the same edge; the q value is preserved across the switch.
REQ-024 Latency: every q update is visible one clock after the inputs are sampled.

Reset
REQ-025 rst_n low at a rising edge: q <= RST_VAL, qbar <= ~RST_VAL, chg <= 0, regardless of all other inputs.
REQ-026 rst_n asserted mid-count or mid-toggle aborts the operation; no partial update is retained.
REQ-027 tc after reset follows REQ-020 evaluated on RST_VAL.

Configuration
REQ-028 Macro JK_CNT_DOWN_EN: when defined, adds input dn (1 bit); in counter mode dn=1 makes bit i toggle when q[i-1:0] are all zeros (q <= q-1 mod 2^WIDTH), and tc = mode & en & (q == 0) while dn=1.
REQ-029 Without JK_CNT_DOWN_EN, port dn does not exist and the counter counts up only.

Verification
REQ-030 WIDTH=8, RST_VAL=8'h5A, rst_n low for 1 edge -> q=8'h5A, qbar=8'hA5, chg=0.
REQ-031 JK mode, q=8'h0F, j=8'hF0, k=8'h3C, en=1 -> next q=8'hF3, chg=1.
REQ-032 Counter mode, en=1, q=8'hFE -> tc=0, then q=8'hFF with tc=1, then q=8'h00 with tc=0 and chg=1.
REQ-033 clr=1 and preset=1 together with mode=1, en=1 -> q=8'h00; preset alone -> q=8'hFF.
REQ-034 Counter mode, q=8'h10, en=0 for 3 edges -> q stays 8'h10, chg=0; rst_n low on the next edge overrides en=1 -> q=RST_VAL.
REQ-035 JK_CNT_DOWN_EN defined, counter mode, dn=1, q=8'h01 -> 8'h00 (tc=1) -> 8'hFF.
